// File: rtl/and_32_pkg.sv
// Shared ALU32 types: the data word, its boundary constants
// and the status flag bundle used by the result/flag stages.
package alu32_pkg;

  typedef logic signed [31:0] word_t;

  localparam word_t WORD_ZERO = 32'sh0000_0000;
  localparam word_t WORD_ONES = 32'shFFFF_FFFF;

  typedef struct packed {
    logic zero;
    logic ones;
    logic sign;
  } alu_flags_t;

endpackage

// File: rtl/and_32_if.sv
// Operand/result bundle of the AND unit, with a driver side
// (master) and a unit side (slave).
interface and_32_if;
  import alu32_pkg::*;

  word_t x;
  word_t y;
  logic  in_valid;
  word_t z;
  word_t z_q;
  logic  out_valid;
  logic  zero_q;
  logic  ones_q;
  logic  sign_q;

  modport master (
    output x, y, in_valid,
    input  z, z_q, out_valid,
    input  zero_q, ones_q, sign_q
  );

  modport slave (
    input  x, y, in_valid,
    output z, z_q, out_valid,
    output zero_q, ones_q, sign_q
  );

endinterface

// File: rtl/and_32_slice.sv
// 8-bit bitwise AND lane; four of these form the 32-bit
// combinational result.
module and_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z
);

  assign z = a & b;

endmodule

// File: rtl/and_32.sv
// 32-bit bitwise AND: combinational result for the ALU mux
// plus a one-cycle registered copy with zero/ones/sign flags.
module and_32
  import alu32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic                    in_valid,
  output logic signed [WIDTH-1:0] z,
  output logic signed [WIDTH-1:0] z_q,
  output logic                    out_valid,
  output logic                    zero_q,
  output logic                    ones_q,
  output logic                    sign_q
);

  localparam int SLICES = WIDTH / 8;

  genvar g;
  for (g = 0; g < SLICES; g++) begin : g_slice
    and_slice #(.W(8)) u_slice (
      .a (x[g*8 +: 8]),
      .b (y[g*8 +: 8]),
      .z (z[g*8 +: 8])
    );
  end

  alu_flags_t flags_d;
  alu_flags_t flags_q;

  // Flags come from the same combinational word that z_q loads.
  always_comb begin
    flags_d      = '0;
    flags_d.zero = ~|z;
    flags_d.ones = &z;
    flags_d.sign = z[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q       <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        z_q     <= z;
        flags_q <= flags_d;
      end
    end
  end

  assign zero_q = flags_q.zero;
  assign ones_q = flags_q.ones;
  assign sign_q = flags_q.sign;

endmodule

// File: tb/tb_and_32.sv
// Self-checking bench for and_32: scoreboarded captures,
// corners, patterns, walking ones, random, flags, reset.
module tb_and_32;
  import alu32_pkg::*;

  logic clk;
  logic rst_n;
  and_32_if bus();

  and_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (bus.x),
    .y         (bus.y),
    .in_valid  (bus.in_valid),
    .z         (bus.z),
    .z_q       (bus.z_q),
    .out_valid (bus.out_valid),
    .zero_q    (bus.zero_q),
    .ones_q    (bus.ones_q),
    .sign_q    (bus.sign_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  word_t sb[$];
  word_t held;

  function automatic logic [2:0] flags_of(input word_t w);
    logic [31:0] u;
    u = w;
    return {u == 32'h0, u == 32'hFFFF_FFFF, u[31]};
  endfunction

  function automatic word_t pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic drive(input word_t a, input word_t b, input logic v);
    bus.x = a;
    bus.y = b;
    bus.in_valid = v;
    if (v) sb.push_back(a & b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'sh0, 32'sh0, 1'b0);
    #2;
    n_vec++;
    if ({bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, bus.out_valid} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_regs got z_q=%h flags=%b%b%b ov=%b want all 0",
               bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, bus.out_valid);
    end
    bus.x = 32'sh1234_5678;
    bus.y = 32'shFFFF_0000;
    #1;
    n_vec++;
    if (bus.z !== 32'sh1234_0000) begin
      n_err++;
      $display("FAIL reset_z got %h want 12340000", bus.z);
    end
    bus.in_valid = 1'b1;
    tick();
    n_vec++;
    if ({bus.z_q, bus.out_valid} !== 33'h0) begin
      n_err++;
      $display("FAIL reset_hold got z_q=%h ov=%b want 0/0", bus.z_q, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    held = '0;
  endtask

  task automatic test_corners();
    word_t xa[4] = '{32'sh0, 32'shFFFF_FFFF, 32'shFFFF_FFFF, 32'sh0};
    word_t ya[4] = '{32'sh0, 32'shFFFF_FFFF, 32'sh0, 32'shFFFF_FFFF};
    word_t za[4] = '{32'sh0, 32'shFFFF_FFFF, 32'sh0, 32'sh0};
    word_t e;
    for (int i = 0; i < 4; i++) begin
      drive(xa[i], ya[i], 1'b1);
      #1;
      n_vec++;
      if (bus.z !== za[i]) begin
        n_err++;
        $display("FAIL corner_z[%0d] got %h want %h", i, bus.z, za[i]);
      end
      tick();
      e = pop_exp();
      n_vec++;
      if ({bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, bus.out_valid}
          !== {e, flags_of(e), 1'b1}) begin
        n_err++;
        $display("FAIL corner_q[%0d] got z_q=%h flags=%b%b%b ov=%b want %h %b 1",
                 i, bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, bus.out_valid,
                 e, flags_of(e));
      end
      held = e;
    end
  endtask

  task automatic test_patterns();
    word_t xa[4] = '{32'shAAAA_AAAA, 32'shF0F0_F0F0, 32'sh1234_5678, 32'sh8000_0001};
    word_t ya[4] = '{32'sh5555_5555, 32'sh0F0F_0F0F, 32'shFFFF_0000, 32'sh7FFF_FFFF};
    word_t za[4] = '{32'sh0, 32'sh0, 32'sh1234_0000, 32'sh0000_0001};
    word_t e;
    for (int i = 0; i < 4; i++) begin
      drive(xa[i], ya[i], 1'b1);
      #1;
      n_vec++;
      if (bus.z !== za[i]) begin
        n_err++;
        $display("FAIL pattern_z[%0d] got %h want %h", i, bus.z, za[i]);
      end
      tick();
      e = pop_exp();
      n_vec++;
      if ({bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q}
          !== {e, flags_of(e)}) begin
        n_err++;
        $display("FAIL pattern_q[%0d] got z_q=%h flags=%b%b%b want %h %b",
                 i, bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, e, flags_of(e));
      end
      held = e;
    end
  endtask

  task automatic test_walking();
    word_t a;
    word_t b;
    word_t e;
    logic [31:0] one;
    for (int i = 0; i < 32; i++) begin
      for (int s = 0; s < 2; s++) begin
        one = 32'h1 << i;
        a = s ? 32'shFFFF_FFFF : word_t'(one);
        b = s ? word_t'(one) : 32'shFFFF_FFFF;
        drive(a, b, 1'b1);
        #1;
        n_vec++;
        if (bus.z !== word_t'(one)) begin
          n_err++;
          $display("FAIL walk_z[%0d,%0d] got %h want %h", i, s, bus.z, one);
        end
        tick();
        e = pop_exp();
        n_vec++;
        if ({bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q}
            !== {e, flags_of(e)}) begin
          n_err++;
          $display("FAIL walk_q[%0d,%0d] got %h %b%b%b want %h %b", i, s,
                   bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, e, flags_of(e));
        end
        if (i == 31) begin
          n_vec++;
          if (bus.sign_q !== 1'b1 || bus.z_q !== 32'sh8000_0000) begin
            n_err++;
            $display("FAIL walk31_sign got sign_q=%b z_q=%h want 1 80000000",
                     bus.sign_q, bus.z_q);
          end
        end
        held = e;
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t a;
    word_t b;
    word_t e;
    for (int i = 0; i < 500; i++) begin
      a = word_t'($urandom);
      b = word_t'($urandom);
      drive(a, b, 1'b1);
      #1;
      n_vec++;
      if (bus.z !== (a & b)) begin
        n_err++;
        $display("FAIL rand_z[%0d] x=%h y=%h got %h want %h", i, a, b, bus.z, a & b);
      end
      tick();
      e = pop_exp();
      n_vec++;
      if ({bus.z_q, bus.out_valid} !== {e, 1'b1}) begin
        n_err++;
        $display("FAIL rand_q[%0d] got z_q=%h ov=%b want %h 1",
                 i, bus.z_q, bus.out_valid, e);
      end
      held = e;
    end
  endtask

  task automatic test_flags_valid();
    word_t e;
    drive(32'shFFFF_FFFF, 32'shFFFF_FFFF, 1'b1);
    tick();
    e = pop_exp();
    n_vec++;
    if ({bus.ones_q, bus.zero_q, bus.sign_q, bus.out_valid} !== 4'b1011
        || bus.z_q !== e) begin
      n_err++;
      $display("FAIL flags_ones got on=%b zo=%b sg=%b ov=%b z_q=%h want 1 0 1 1 %h",
               bus.ones_q, bus.zero_q, bus.sign_q, bus.out_valid, bus.z_q, e);
    end
    drive(32'shAAAA_AAAA, 32'sh5555_5555, 1'b1);
    tick();
    e = pop_exp();
    n_vec++;
    if ({bus.zero_q, bus.ones_q, bus.sign_q} !== 3'b100 || bus.z_q !== e) begin
      n_err++;
      $display("FAIL flags_zero got zo=%b on=%b sg=%b z_q=%h want 1 0 0 %h",
               bus.zero_q, bus.ones_q, bus.sign_q, bus.z_q, e);
    end
    held = e;
    drive(32'sh7654_3210, 32'shFFFF_FFFF, 1'b0);
    #1;
    n_vec++;
    if (bus.z !== 32'sh7654_3210) begin
      n_err++;
      $display("FAIL idle_z got %h want 76543210", bus.z);
    end
    tick();
    n_vec++;
    if ({bus.z_q, bus.zero_q, bus.out_valid} !== {held, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL idle_hold got z_q=%h zo=%b ov=%b want %h 1 0",
               bus.z_q, bus.zero_q, bus.out_valid, held);
    end
  endtask

  task automatic test_reset_mid();
    word_t e;
    drive(32'shFFFF_FFFF, 32'shC0DE_1234, 1'b1);
    tick();
    e = pop_exp();
    n_vec++;
    if ({bus.z_q, bus.out_valid, bus.sign_q} !== {e, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset got z_q=%h ov=%b sg=%b want %h 1 1",
               bus.z_q, bus.out_valid, bus.sign_q, e);
    end
    bus.x = 32'shFFFF_FFFF;
    bus.y = 32'shFFFF_FFFF;
    bus.in_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, bus.out_valid} !== 36'h0) begin
      n_err++;
      $display("FAIL mid_reset got z_q=%h flags=%b%b%b ov=%b want all 0",
               bus.z_q, bus.zero_q, bus.ones_q, bus.sign_q, bus.out_valid);
    end
    n_vec++;
    if (bus.z !== 32'shFFFF_FFFF) begin
      n_err++;
      $display("FAIL mid_reset_z got %h want ffffffff", bus.z);
    end
    tick();
    n_vec++;
    if ({bus.z_q, bus.out_valid} !== 33'h0) begin
      n_err++;
      $display("FAIL reset_discard got z_q=%h ov=%b want 0 0", bus.z_q, bus.out_valid);
    end
    rst_n = 1'b1;
    drive(32'sh0F0F_0F0F, 32'sh00FF_00FF, 1'b1);
    tick();
    e = pop_exp();
    n_vec++;
    if ({bus.z_q, bus.out_valid} !== {e, 1'b1} || e !== 32'sh000F_000F) begin
      n_err++;
      $display("FAIL post_reset got z_q=%h ov=%b want 000f000f 1",
               bus.z_q, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_corners();
    test_patterns();
    test_walking();
    test_back_to_back();
    test_flags_valid();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/and_32.md
# and_32

Bitwise 32-bit AND unit of the alu32 datapath. Produces `z = x & y` combinationally for the ALU result mux, plus a one-cycle registered copy of the result with status flags for the pipelined result/flag stage. Operands are treated as signed 32-bit words. Signedness does not affect the bitwise result.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width. Only 32 is verified.

Ports:
- `clk`  in  1  rising-edge clock for the registered stage.
- `rst_n`  in  1  asynchronous, active-low reset.
- `x`  in  signed [31:0]  operand A.
- `y`  in  signed [31:0]  operand B.
- `in_valid`  in  1  qualifies `x`/`y` for capture into the registered stage.
- `z`  out  signed [31:0]  combinational `x & y`.
- `z_q`  out  signed [31:0]  registered result.
- `out_valid`  out  1  `z_q` and flags hold a captured result.
- `zero_q`  out  1  registered flag: result == 0.
- `ones_q`  out  1  registered flag: result == 32'hFFFF_FFFF.
- `sign_q`  out  1  registered flag: result bit 31.

## Operation
- `z[i] = x[i] & y[i]` for all i in 0..31. There is no carry, no sign extension and no width change.
- `z` never depends on `clk`, `rst_n` or `in_valid`, and is valid during reset.
- `z` must never be X/Z when `x` and `y` are known. The 4-state compare `z !== (x & y)` must hold.
- On a rising `clk` with `in_valid=1`:
  - `z_q` <= `x & y`
  - `zero_q` <= (`x & y` == 0)
  - `ones_q` <= (`x & y` == all ones)
  - `sign_q` <= bit 31 of `x & y`
  - `out_valid` <= 1
- On a rising `clk` with `in_valid=0`:
  - `out_valid` <= 0
  - `z_q` and the flags hold their previous value.
- Flags are always computed from the same value loaded into `z_q`. `zero_q` and `ones_q` are never both 1.

## Timing
- `z`: zero-cycle latency, purely combinational. It must settle within one time unit of any operand change, with no delta-cycle glitch left at that point.
- Registered stage: latency 1 cycle. `out_valid` is high in the cycle after `in_valid` was sampled high. Back-to-back `in_valid` gives one result per cycle. There is no backpressure.
- Reset: asserting `rst_n` low immediately forces `z_q=0`, `zero_q=0`, `ones_q=0`, `sign_q=0`, `out_valid=0`, independent of `clk`.
- Reset mid-operation: a capture in flight is discarded. The first capture after release is at the first rising edge with `rst_n=1` and `in_valid=1`.
- Operands changing between edges affect only `z`. The registered outputs change only at edges or on reset.

## Structure
- Shared package `alu32_pkg`: `word_t` (signed [31:0]), constants `WORD_ZERO` and `WORD_ONES`, and an `alu_flags_t` struct (zero, ones, sign) reused by the other ALU units.
- One natural sub-module: `and_slice`, an 8-bit bitwise AND. It is instantiated 4x via generate to form the 32-bit result.
- Flag logic and the output register live in the top level.

## Test plan
- Corner cases: for x/y of 0/0, FFFFFFFF/FFFFFFFF, FFFFFFFF/0 and 0/FFFFFFFF, `z` is 0, FFFFFFFF, 0, 0 respectively, and valid 1 time unit after the change.
- Alternating patterns:
  - AAAAAAAA & 55555555 -> 0
  - F0F0F0F0 & 0F0F0F0F -> 0
  - 12345678 & FFFF0000 -> 12340000
  - 80000001 & 7FFFFFFF -> 00000001
- Walking ones:
  - x = 1<<i, y = FFFFFFFF for i = 0..31 -> `z` = 1<<i.
  - Swapped operands give the same result.
  - i = 31 gives 80000000 and `sign_q`=1 after capture.
- Random: 500 $urandom pairs -> `z` === x & y with an error count of 0. With `in_valid=1` each cycle, `z_q` equals the previous cycle's x & y.
- Flags and valid:
  - Capture FFFFFFFF&FFFFFFFF -> next cycle `ones_q`=1, `zero_q`=0, `sign_q`=1, `out_valid`=1.
  - Capture AAAAAAAA&55555555 -> `zero_q`=1.
  - Drop `in_valid` -> `out_valid`=0 and `z_q` holds.
- Reset: pull `rst_n` low between edges while `out_valid`=1 -> all registered outputs are 0 immediately and `z` still tracks x & y.
